// File: rtl/seq_gen_101101_pkg.sv
// Shared definitions for the serial 101101 transmit/detect path:
// FSM state encoding and the default pattern.
package seq_gen_101101_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int          DEFAULT_PATTERN_W = 6;
   localparam logic [5:0]  DEFAULT_PATTERN   = 6'b101101;

endpackage

// File: rtl/seq_gen_101101.sv
// Serial pattern transmitter: shifts PATTERN out MSB-first, repeat_n times,
// with gap_n idle zero bits between repeats. All outputs are registered.
module seq_gen_101101
   import seq_gen_101101_pkg::*;
#(
   parameter int                   PATTERN_W = DEFAULT_PATTERN_W,
   parameter logic [PATTERN_W-1:0] PATTERN   = PATTERN_W'(DEFAULT_PATTERN),
   parameter int                   CNT_W     = 8,
   parameter int                   GAP_W     = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] repeat_n,
   input  logic [GAP_W-1:0] gap_n,
   input  logic             abort,
   output logic             data,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   localparam int                IDX_W   = $clog2(PATTERN_W);
   localparam logic [IDX_W-1:0]  MSB_IDX = IDX_W'(PATTERN_W - 1);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
   logic [CNT_W-1:0]   rep_q, rep_d;
   logic [GAP_W-1:0]   gap_len_q, gap_len_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic               data_q, data_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [IDX_W-1:0]   idx_dec;

   assign idx_dec = bit_idx_q - IDX_W'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         bit_idx_q <= '0;
         rep_q     <= '0;
         gap_len_q <= '0;
         gap_cnt_q <= '0;
         data_q    <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_idx_q <= bit_idx_d;
         rep_q     <= rep_d;
         gap_len_q <= gap_len_d;
         gap_cnt_q <= gap_cnt_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Outputs are computed one cycle ahead so that they can be registered;
   // rep_q holds the repeats still to finish, including the one in flight.
   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      rep_d     = rep_q;
      gap_len_d = gap_len_q;
      gap_cnt_d = gap_cnt_q;
      data_d    = 1'b0;
      valid_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               rep_d     = repeat_n;
               gap_len_d = gap_n;
               if (repeat_n != '0) begin
                  state_d   = SHIFT;
                  bit_idx_d = MSB_IDX;
                  data_d    = PATTERN[MSB_IDX];
                  valid_d   = 1'b1;
                  busy_d    = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end

         SHIFT: begin
            busy_d = 1'b1;
            if (bit_idx_q != '0) begin
               bit_idx_d = idx_dec;
               data_d    = PATTERN[idx_dec];
               valid_d   = 1'b1;
            end else if (rep_q > CNT_W'(1)) begin
               rep_d = rep_q - CNT_W'(1);
               if (gap_len_q != '0) begin
                  state_d   = GAP;
                  gap_cnt_d = gap_len_q;
               end else begin
                  bit_idx_d = MSB_IDX;
                  data_d    = PATTERN[MSB_IDX];
                  valid_d   = 1'b1;
               end
            end else begin
               state_d = IDLE;
               rep_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end

         GAP: begin
            busy_d = 1'b1;
            if (gap_cnt_q > GAP_W'(1)) begin
               gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end else begin
               gap_cnt_d = '0;
               state_d   = SHIFT;
               bit_idx_d = MSB_IDX;
               data_d    = PATTERN[MSB_IDX];
               valid_d   = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort only cancels a running transfer; in IDLE a coincident start wins.
      if (abort && (state_q != IDLE)) begin
         state_d   = IDLE;
         bit_idx_d = '0;
         rep_d     = '0;
         gap_cnt_d = '0;
         data_d    = 1'b0;
         valid_d   = 1'b0;
         busy_d    = 1'b0;
         done_d    = 1'b0;
      end
   end

   assign data  = data_q;
   assign valid = valid_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule
